// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - stretches single-cycle event strobes into LED pulses with a queued backlog
module led_pulse_stretcher #(
    parameter int c_ON_CYCLES   = 250000,
    parameter int c_OFF_CYCLES  = 250000,
    parameter int c_MAX_PENDING = 15
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Rst_n,
    input  logic                                 i_Event,
    input  logic                                 i_Clear,
    output logic                                 o_LED,
    output logic                                 o_Busy,
    output logic [$clog2(c_MAX_PENDING+1)-1:0]   o_Pending,
    output logic                                 o_Overflow
);

    localparam int c_MAX_PHASE = (c_ON_CYCLES > c_OFF_CYCLES) ? c_ON_CYCLES : c_OFF_CYCLES;
    localparam int W_CNT       = $clog2(c_MAX_PHASE + 1);
    localparam int W_PEND      = $clog2(c_MAX_PENDING + 1);

    localparam logic [W_CNT-1:0]  c_ON_LAST  = W_CNT'(c_ON_CYCLES - 1);
    localparam logic [W_CNT-1:0]  c_OFF_LAST = W_CNT'(c_OFF_CYCLES - 1);
    localparam logic [W_PEND-1:0] c_PEND_MAX = W_PEND'(c_MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t              r_state;
    logic [W_CNT-1:0]    r_cnt;
    logic [W_PEND-1:0]   r_pending;
    logic                r_overflow;
    logic                r_led;
    logic                r_busy;

    logic w_off_last;
    logic w_start_queued;
    logic w_start_direct;
    logic w_inc;

    // The last off-gap cycle is the only point where a new pulse may follow an old one.
    assign w_off_last     = (r_state == S_OFF) && (r_cnt == c_OFF_LAST);
    // A queued event is consumed when the gap ends with a backlog.
    assign w_start_queued = w_off_last && (r_pending != '0);
    // An event that finds nothing ahead of it starts its pulse without touching the backlog;
    // this also covers an event landing on the final gap cycle with an empty backlog.
    assign w_start_direct = i_Event && ((r_state == S_IDLE) || (w_off_last && (r_pending == '0)));
    assign w_inc          = i_Event && !w_start_direct;

    // Pulse sequencer, backlog counter and sticky overflow, all with registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
        end else if (i_Clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_inc && !w_start_queued) begin
                if (r_pending == c_PEND_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + W_PEND'(1);
                end
            end else if (w_start_queued && !w_inc) begin
                r_pending <= r_pending - W_PEND'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (i_Event) begin
                        r_state <= S_ON;
                        r_cnt   <= '0;
                        r_led   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (r_cnt == c_ON_LAST) begin
                        r_state <= S_OFF;
                        r_cnt   <= '0;
                        r_led   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + W_CNT'(1);
                    end
                end
                S_OFF: begin
                    if (r_cnt == c_OFF_LAST) begin
                        r_cnt <= '0;
                        if (w_start_queued || w_start_direct) begin
                            r_state <= S_ON;
                            r_led   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + W_CNT'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_LED      = r_led;
    assign o_Busy     = r_busy;
    assign o_Pending  = r_pending;
    assign o_Overflow = r_overflow;

endmodule
